// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_P1   = 3'd1,
    SEL_P2   = 3'd2,
    SEL_M1   = 3'd3,
    SEL_M2   = 3'd4
  } sel_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_mul_r4_if.sv
// Execution-bus handshake and operand/result bundle of the Booth multiplier.
interface booth_mul_r4_if #(parameter int unsigned WIDTH = 64);

  logic               op_start;
  logic               op_clear;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   multiplicand;
  logic               op_busy;
  logic               op_done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output op_start, op_clear, signed_mode, multiplier, multiplicand,
    input  op_busy, op_done, result
  );

  modport slave (
    input  op_start, op_clear, signed_mode, multiplier, multiplicand,
    output op_busy, op_done, result
  );

endinterface

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth digit encoder: maps a 3-bit multiplier window to an addend and carry-in.
module booth_r4_enc
  import booth_pkg::*;
#(
  parameter int unsigned EW = 66
) (
  input  logic [2:0] win,
  input  logic [EW:0] mx,
  input  logic [EW:0] mx2,
  output logic [EW:0] addend_c,
  output logic        cin_c
);

  sel_t sel;

  always_comb begin
    sel = SEL_ZERO;
    case (win)
      3'b001, 3'b010: sel = SEL_P1;
      3'b011:         sel = SEL_P2;
      3'b100:         sel = SEL_M2;
      3'b101, 3'b110: sel = SEL_M1;
      default:        sel = SEL_ZERO;
    endcase
  end

  // Negative digits subtract as one's complement plus carry-in.
  always_comb begin
    addend_c = '0;
    cin_c    = 1'b0;
    case (sel)
      SEL_P1: addend_c = mx;
      SEL_P2: addend_c = mx2;
      SEL_M1: begin
        addend_c = ~mx;
        cin_c    = 1'b1;
      end
      SEL_M2: begin
        addend_c = ~mx2;
        cin_c    = 1'b1;
      end
      default: begin
        addend_c = '0;
        cin_c    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_mul_r4.sv
// Iterative radix-4 Booth multiplier, two multiplier bits retired per cycle,
// with start/clear handshake and a registered product.
module booth_mul_r4
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  booth_mul_r4_if.slave  bus
);

  localparam int unsigned EW    = WIDTH + 2;
  localparam int unsigned AW    = EW + 1;
  localparam int unsigned NITER = EW / 2;
  localparam int unsigned CW    = (clog2(NITER) < 1) ? 1 : clog2(NITER);

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CW-1:0]      cnt_q;
  logic [AW-1:0]      mx_q, mx2_q, a_q;
  logic [EW-1:0]      q_q;
  logic               qm1_q;
  logic [2*WIDTH-1:0] result_q;

  logic               start_ok;
  logic               last_iter;
  logic [EW-1:0]      mx_ext, q_ext;
  logic [AW-1:0]      addend;
  logic               cin;
  logic [AW-1:0]      a_sum, a_sh;
  logic [EW-1:0]      q_sh;

  assign start_ok  = bus.op_start && !bus.op_clear;
  assign last_iter = (cnt_q == CW'(NITER - 1));

  // Two extra bits keep the top Booth digit non-negative for unsigned operands.
  assign mx_ext = bus.signed_mode ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                  : {2'b00, bus.multiplicand};
  assign q_ext  = bus.signed_mode ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                  : {2'b00, bus.multiplier};

  booth_r4_enc #(.EW(EW)) u_enc (
    .win      ({q_q[1:0], qm1_q}),
    .mx       (mx_q),
    .mx2      (mx2_q),
    .addend_c (addend),
    .cin_c    (cin)
  );

  // Single accumulate, then arithmetic shift of {A, Q, q_m1} right by two.
  assign a_sum = a_q + addend + AW'(cin);
  assign a_sh  = {a_sum[AW-1], a_sum[AW-1], a_sum[AW-1:2]};
  assign q_sh  = {a_sum[1:0], q_q[EW-1:2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = EXEC;
      end
      EXEC: begin
        if (bus.op_clear)   state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE: begin
        if (bus.op_clear)  state_d = IDLE;
        else if (start_ok) state_d = EXEC;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == EXEC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      mx_q     <= '0;
      mx2_q    <= '0;
      a_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            cnt_q <= '0;
            mx_q  <= {mx_ext[EW-1], mx_ext};
            mx2_q <= {mx_ext, 1'b0};
            a_q   <= '0;
            q_q   <= q_ext;
            qm1_q <= 1'b0;
          end
        end
        EXEC: begin
          if (bus.op_clear) begin
            cnt_q <= '0;
          end else begin
            a_q   <= a_sh;
            q_q   <= q_sh;
            qm1_q <= q_q[1];
            cnt_q <= last_iter ? '0 : cnt_q + CW'(1);
            if (last_iter) result_q <= {a_sh[2*WIDTH-EW-1:0], q_sh};
          end
        end
        default: begin
          cnt_q <= '0;
          mx_q  <= '0;
          mx2_q <= '0;
          a_q   <= '0;
          q_q   <= '0;
          qm1_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_busy = busy_q;
  assign bus.op_done = done_q;
  assign bus.result  = result_q;

endmodule
